// File: rtl/sprite_pkg.sv
// Shared constants and types for the per-pixel sprite address generator.
//   SPRITE_W / SPRITE_H : standing-sprite dimensions in pixels (ROM is W*H entries)
//   ADDR_W              : sprite ROM address width
//   BLINK_FRAMES        : frames a player blinks after being hurt
//   CNT_W               : blink counter width
//   coord_t             : 10-bit screen coordinate
package sprite_pkg;

    localparam int unsigned SPRITE_W     = 30;
    localparam int unsigned SPRITE_H     = 45;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned BLINK_FRAMES = 60;
    localparam int unsigned CNT_W        = 6;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sprite_hit_addr.sv
// Per-player hit test, mirroring, ROM address pipeline and blink counter.
// Ports:
//   Clk, Reset_n        pixel clock, asynchronous active-low reset
//   frame_edge          one-cycle pulse at the start of each frame
//   hurt                one-cycle pulse that (re)starts the blink
//   pix_valid           DrawX/DrawY are inside the visible area
//   DrawX, DrawY        current pixel coordinate
//   PX, PY              top-left corner of this player's sprite
//   p_left              player faces left; mirror the sprite horizontally
//   rd_addr, rd_en      ROM address and read enable, 2 cycles after the pixel
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W     = sprite_pkg::SPRITE_W,
    parameter int unsigned SPRITE_H     = sprite_pkg::SPRITE_H,
    parameter int unsigned BLINK_FRAMES = sprite_pkg::BLINK_FRAMES
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_edge,
    input  logic              hurt,
    input  logic              pix_valid,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  coord_t            PX,
    input  coord_t            PY,
    input  logic              p_left,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en
);

    localparam int unsigned ColW  = $clog2(SPRITE_W);
    localparam int unsigned RowW  = $clog2(SPRITE_H);
    localparam int unsigned ProdW = $clog2(SPRITE_W * SPRITE_H);

    // Blink counter
    logic [CNT_W-1:0] cnt_q;
    logic             visible;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (hurt) begin
            // Load wins over a coincident frame edge; also restarts an active blink.
            cnt_q <= CNT_W'(BLINK_FRAMES);
        end else if (frame_edge && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Toggles every 4 frames while blinking.
    assign visible = (cnt_q == '0) | cnt_q[2];

    // Stage 1: hit test and mirrored column
    // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
    logic [10:0]     rel_x;
    logic [10:0]     rel_y;
    logic            in_x;
    logic            in_y;
    logic            hit_c;
    logic [ColW-1:0] col_c;

    assign rel_x = {1'b0, DrawX} - {1'b0, PX};
    assign rel_y = {1'b0, DrawY} - {1'b0, PY};
    assign in_x  = ~rel_x[10] & (rel_x[9:0] < 10'(SPRITE_W));
    assign in_y  = ~rel_y[10] & (rel_y[9:0] < 10'(SPRITE_H));
    assign hit_c = pix_valid & visible & in_x & in_y;
    assign col_c = p_left ? ColW'(SPRITE_W - 1) - rel_x[ColW-1:0] : rel_x[ColW-1:0];

    logic            hit_s1_q;
    logic [ColW-1:0] col_s1_q;
    logic [RowW-1:0] row_s1_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_s1_q <= 1'b0;
            col_s1_q <= '0;
            row_s1_q <= '0;
        end else begin
            hit_s1_q <= hit_c;
            col_s1_q <= hit_c ? col_c : '0;
            row_s1_q <= hit_c ? rel_y[RowW-1:0] : '0;
        end
    end

    // Stage 2: row * SPRITE_W + col
    logic [ProdW-1:0] row_base;
    logic [ProdW-1:0] addr_c;

    if (SPRITE_W == 30) begin : gen_mul_shift
        // 30*y = 32*y - 2*y
        assign row_base = (ProdW'(row_s1_q) << 5) - (ProdW'(row_s1_q) << 1);
    end else begin : gen_mul_generic
        assign row_base = ProdW'(row_s1_q) * ProdW'(SPRITE_W);
    end

    assign addr_c = row_base + ProdW'(col_s1_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_addr <= '0;
            rd_en   <= 1'b0;
        end else begin
            rd_addr <= hit_s1_q ? ADDR_W'(addr_c) : '0;
            rd_en   <= hit_s1_q;
        end
    end

endmodule

// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator for two players, upstream of the standing-sprite ROMs.
// Ports:
//   Clk, Reset_n                                pixel clock, asynchronous active-low reset
//   frame_clk                                   frame tick; rising edge starts a new frame
//   pix_valid, DrawX, DrawY                     current pixel and its visibility
//   P1X, P1Y, P2X, P2Y                          sprite top-left corners
//   p1_left, p2_left                            facing left (mirror)
//   hurt_1, hurt_2                              one-cycle pulses starting the blink
//   stand_read_address, stand_read_address_2    ROM addresses (2-cycle latency)
//   is_player, is_player_2                      ROM read enables (2-cycle latency)
//   hit_1_q, hit_2_q                            enables delayed to line up with ROM data
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W     = sprite_pkg::SPRITE_W,
    parameter int unsigned SPRITE_H     = sprite_pkg::SPRITE_H,
    parameter int unsigned BLINK_FRAMES = sprite_pkg::BLINK_FRAMES
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              pix_valid,
    input  coord_t            DrawX,
    input  coord_t            DrawY,
    input  coord_t            P1X,
    input  coord_t            P1Y,
    input  coord_t            P2X,
    input  coord_t            P2Y,
    input  logic              p1_left,
    input  logic              p2_left,
    input  logic              hurt_1,
    input  logic              hurt_2,
    output logic [ADDR_W-1:0] stand_read_address,
    output logic [ADDR_W-1:0] stand_read_address_2,
    output logic              is_player,
    output logic              is_player_2,
    output logic              hit_1_q,
    output logic              hit_2_q
);

    logic frame_clk_d;
    logic frame_edge;

    assign frame_edge = frame_clk & ~frame_clk_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_d <= 1'b0;
            hit_1_q     <= 1'b0;
            hit_2_q     <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            hit_1_q     <= is_player;
            hit_2_q     <= is_player_2;
        end
    end

    sprite_hit_addr #(
        .SPRITE_W     (SPRITE_W),
        .SPRITE_H     (SPRITE_H),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_p1 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_edge (frame_edge),
        .hurt       (hurt_1),
        .pix_valid  (pix_valid),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PX         (P1X),
        .PY         (P1Y),
        .p_left     (p1_left),
        .rd_addr    (stand_read_address),
        .rd_en      (is_player)
    );

    sprite_hit_addr #(
        .SPRITE_W     (SPRITE_W),
        .SPRITE_H     (SPRITE_H),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_p2 (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_edge (frame_edge),
        .hurt       (hurt_2),
        .pix_valid  (pix_valid),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PX         (P2X),
        .PY         (P2Y),
        .p_left     (p2_left),
        .rd_addr    (stand_read_address_2),
        .rd_en      (is_player_2)
    );

endmodule

// File: tb/tb_sprite_addr_gen.sv
module tb_sprite_addr_gen;

    localparam int W  = 30;
    localparam int H  = 45;
    localparam int BF = 60;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY, P1X, P1Y, P2X, P2Y;
    logic        p1_left, p2_left, hurt_1, hurt_2;
    logic [18:0] stand_read_address, stand_read_address_2;
    logic        is_player, is_player_2, hit_1_q, hit_2_q;

    sprite_addr_gen dut (
        .Clk                  (Clk),
        .Reset_n              (Reset_n),
        .frame_clk            (frame_clk),
        .pix_valid            (pix_valid),
        .DrawX                (DrawX),
        .DrawY                (DrawY),
        .P1X                  (P1X),
        .P1Y                  (P1Y),
        .P2X                  (P2X),
        .P2Y                  (P2Y),
        .p1_left              (p1_left),
        .p2_left              (p2_left),
        .hurt_1               (hurt_1),
        .hurt_2               (hurt_2),
        .stand_read_address   (stand_read_address),
        .stand_read_address_2 (stand_read_address_2),
        .is_player            (is_player),
        .is_player_2          (is_player_2),
        .hit_1_q              (hit_1_q),
        .hit_2_q              (hit_2_q)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_cnt1, m_cnt2;
    bit          m_fc_prev;
    logic [11:0] q1[$];
    logic [11:0] q2[$];
    logic [41:0] exp_vec;
    logic [41:0] obs;

    assign obs = {is_player, is_player_2, hit_1_q, hit_2_q,
                  stand_read_address, stand_read_address_2};

    // {hit, 11-bit address} for one pixel against one player.
    function automatic logic [11:0] pix_model(int dx, int dy, int px, int py, bit left,
                                              bit valid, int cnt);
        int rx;
        int ry;
        int col;
        bit vis;
        rx  = dx - px;
        ry  = dy - py;
        vis = (cnt == 0) || ((cnt % 8) >= 4);
        if (!valid || !vis || rx < 0 || rx >= W || ry < 0 || ry >= H) return 12'd0;
        col = left ? (W - 1 - rx) : rx;
        return {1'b1, 11'(ry * W + col)};
    endfunction

    task automatic model_reset();
        m_cnt1    = 0;
        m_cnt2    = 0;
        m_fc_prev = 1'b0;
        q1        = '{12'd0, 12'd0, 12'd0};
        q2        = '{12'd0, 12'd0, 12'd0};
        exp_vec   = '0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge, end at negedge.
    task automatic step();
        bit fe;
        @(posedge Clk);
        fe        = frame_clk && !m_fc_prev;
        m_fc_prev = frame_clk;
        q1.push_back(pix_model(int'(DrawX), int'(DrawY), int'(P1X), int'(P1Y), p1_left,
                               pix_valid, m_cnt1));
        q2.push_back(pix_model(int'(DrawX), int'(DrawY), int'(P2X), int'(P2Y), p2_left,
                               pix_valid, m_cnt2));
        while (q1.size() > 3) void'(q1.pop_front());
        while (q2.size() > 3) void'(q2.pop_front());
        if (hurt_1) m_cnt1 = BF; else if (fe && m_cnt1 > 0) m_cnt1--;
        if (hurt_2) m_cnt2 = BF; else if (fe && m_cnt2 > 0) m_cnt2--;
        @(negedge Clk);
        exp_vec = {q1[1][11], q2[1][11], q1[0][11], q2[0][11],
                   8'd0, q1[1][10:0], 8'd0, q2[1][10:0]};
    endtask

    task automatic set_pix(int dx, int dy);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        pix_valid = 1'b1;
        hurt_1    = 1'b0;
        hurt_2    = 1'b0;
        p1_left   = 1'b0;
        p2_left   = 1'b0;
        P1X = 10'd100; P1Y = 10'd200; P2X = 10'd900; P2Y = 10'd700;
        set_pix(100, 200);
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (obs !== 42'd0) begin
                failures++;
                $display("FAIL reset_hold: got %h want 0", obs);
            end
        end
        model_reset();
        Reset_n = 1'b1;
        step();
        checks++;
        if (is_player !== 1'b0 || obs !== exp_vec) begin
            failures++;
            $display("FAIL reset_lat1: got %h want %h (is_player 0)", obs, exp_vec);
        end
        step();
        checks++;
        if ({is_player, stand_read_address} !== {1'b1, 19'd0}) begin
            failures++;
            $display("FAIL reset_lat2: got en=%b addr=%0d want en=1 addr=0",
                     is_player, stand_read_address);
        end
        step();
        checks++;
        if (hit_1_q !== 1'b1 || obs !== exp_vec) begin
            failures++;
            $display("FAIL reset_lat3: got %h want %h", obs, exp_vec);
        end
        // Asynchronous reset mid-line
        Reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== 42'd0) begin
            failures++;
            $display("FAIL reset_async: got %h want 0", obs);
        end
        @(negedge Clk);
        model_reset();
        Reset_n = 1'b1;
        step();
        checks++;
        if (obs !== 42'd0) begin
            failures++;
            $display("FAIL reset_flush: got %h want 0", obs);
        end
        step();
        checks++;
        if (is_player !== 1'b1 || obs !== exp_vec) begin
            failures++;
            $display("FAIL reset_resume: got %h want %h", obs, exp_vec);
        end
    endtask

    // Hold each pixel for 3 cycles: model check every cycle, constant check at the end.
    task automatic run_table(string name, int n, int dx[4], int dy[4], int ea[4], bit ee[4],
                             bit both);
        for (int i = 0; i < n; i++) begin
            set_pix(dx[i], dy[i]);
            repeat (3) begin
                step();
                checks++;
                if (obs !== exp_vec) begin
                    failures++;
                    $display("FAIL %s_model[%0d]: got %h want %h", name, i, obs, exp_vec);
                end
            end
            checks++;
            if ({is_player, hit_1_q, stand_read_address} !== {ee[i], ee[i], 19'(ea[i])}) begin
                failures++;
                $display("FAIL %s_const[%0d]: got en=%b hq=%b addr=%0d want en=%b addr=%0d",
                         name, i, is_player, hit_1_q, stand_read_address, ee[i], ea[i]);
            end
            if (both) begin
                checks++;
                if ({is_player_2, hit_2_q, stand_read_address_2} !==
                    {ee[i], ee[i], 19'(ea[i])}) begin
                    failures++;
                    $display("FAIL %s_p2[%0d]: got en=%b addr=%0d want en=%b addr=%0d",
                             name, i, is_player_2, stand_read_address_2, ee[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_bounds();
        P1X = 10'd100; P1Y = 10'd200; p1_left = 1'b0; pix_valid = 1'b1;
        run_table("bounds", 4, '{100, 129, 130, 100}, '{200, 244, 200, 245},
                  '{0, 1349, 0, 0}, '{1'b1, 1'b1, 1'b0, 1'b0}, 1'b0);
    endtask

    task automatic test_mirror();
        P1X = 10'd100; P1Y = 10'd200; p1_left = 1'b1;
        run_table("mirror", 3, '{100, 129, 110, 0}, '{201, 201, 244, 0},
                  '{59, 30, 1339, 0}, '{1'b1, 1'b1, 1'b1, 1'b0}, 1'b0);
        p1_left = 1'b0;
    endtask

    task automatic test_clip();
        P1X = 10'd5; P1Y = 10'd200;
        run_table("clip_neg", 1, '{3, 0, 0, 0}, '{200, 0, 0, 0},
                  '{0, 0, 0, 0}, '{1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        P1X = 10'd0;
        run_table("clip_zero", 1, '{0, 0, 0, 0}, '{200, 0, 0, 0},
                  '{0, 0, 0, 0}, '{1'b1, 1'b0, 1'b0, 1'b0}, 1'b0);
        P1X = 10'd100; P1Y = 10'd5;
        run_table("clip_top", 1, '{110, 0, 0, 0}, '{2, 0, 0, 0},
                  '{0, 0, 0, 0}, '{1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
    endtask

    task automatic test_overlap();
        P1X = 10'd50; P1Y = 10'd50; P2X = 10'd50; P2Y = 10'd50;
        run_table("overlap", 1, '{60, 0, 0, 0}, '{70, 0, 0, 0},
                  '{610, 0, 0, 0}, '{1'b1, 1'b0, 1'b0, 1'b0}, 1'b1);
        P2X = 10'd900; P2Y = 10'd700;
    endtask

    task automatic test_blink();
        int hidden = 0;
        P1X = 10'd100; P1Y = 10'd200;
        set_pix(110, 210);
        hurt_1 = 1'b1;
        step();
        hurt_1 = 1'b0;
        for (int f = 0; f < 64; f++) begin
            for (int ph = 0; ph < 2; ph++) begin
                frame_clk = (ph == 0);
                step();
                checks++;
                if (obs !== exp_vec) begin
                    failures++;
                    $display("FAIL blink[%0d.%0d]: got %h want %h", f, ph, obs, exp_vec);
                end
                if (!is_player) hidden++;
            end
        end
        // Counter has expired: solid again
        checks++;
        if (is_player !== 1'b1 || hidden == 0) begin
            failures++;
            $display("FAIL blink_solid: got en=%b hidden=%0d want en=1 hidden>0",
                     is_player, hidden);
        end
        // Hurt coincident with a frame edge: count must be 60 (visible), not 59 (hidden)
        frame_clk = 1'b1;
        hurt_1    = 1'b1;
        step();
        hurt_1    = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL blink_coinc_model: got %h want %h", obs, exp_vec);
            end
        end
        checks++;
        if (is_player !== 1'b1) begin
            failures++;
            $display("FAIL blink_coinc: got en=%b want 1", is_player);
        end
        frame_clk = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                P1X = 10'($urandom_range(0, 1023)); P1Y = 10'($urandom_range(0, 1023));
                P2X = 10'($urandom_range(0, 1023)); P2Y = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) == 0) begin
                    P2X = P1X + 10'($urandom_range(0, 20));
                    P2Y = P1Y + 10'($urandom_range(0, 20));
                end
                p1_left = 1'($urandom);
                p2_left = 1'($urandom);
            end
            pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) begin
                DrawX = P1X + 10'($urandom_range(0, 50)) - 10'd10;
                DrawY = P1Y + 10'($urandom_range(0, 65)) - 10'd10;
            end else begin
                DrawX = P2X + 10'($urandom_range(0, 50)) - 10'd10;
                DrawY = P2Y + 10'($urandom_range(0, 65)) - 10'd10;
            end
            hurt_1    = ($urandom_range(0, 199) == 0);
            hurt_2    = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            step();
            checks++;
            if (obs !== exp_vec) begin
                failures++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec);
            end
        end
        hurt_1 = 1'b0;
        hurt_2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bounds();
        test_mirror();
        test_clip();
        test_overlap();
        test_blink();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
